// File: rtl/noc_route_pkg.sv
// Shared routing constants for the mesh router front ends.
// These are the output-port encoding, the route-source modes and the lookup counter width.
package noc_route_pkg;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  localparam int ROUTE_TABLE = 0;
  localparam int ROUTE_XY    = 1;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/xy_route_logic.sv
// Combinational XY dimension-order port selection for one mesh node.
// The X dimension is resolved before Y, and this node's coordinates are fixed at elaboration.
module xy_route_logic
  import noc_route_pkg::*;
#(
  parameter int INDEX         = 4,
  parameter int MESH_COLS     = 3,
  parameter int DEST_W        = 4,
  parameter int REQUEST_WIDTH = 3
) (
  input  logic [DEST_W-1:0]        dest,
  output logic [REQUEST_WIDTH-1:0] port
);

  localparam logic [DEST_W-1:0] CurX = DEST_W'(INDEX % MESH_COLS);
  localparam logic [DEST_W-1:0] CurY = DEST_W'(INDEX / MESH_COLS);
  localparam logic [DEST_W-1:0] Cols = DEST_W'(MESH_COLS);

  logic [DEST_W-1:0] dstX;
  logic [DEST_W-1:0] dstY;

  always_comb begin
    dstX = dest % Cols;
    dstY = dest / Cols;
    port = REQUEST_WIDTH'(PORT_LOCAL);
    if (dstX > CurX)      port = REQUEST_WIDTH'(PORT_EAST);
    else if (dstX < CurX) port = REQUEST_WIDTH'(PORT_WEST);
    else if (dstY > CurY) port = REQUEST_WIDTH'(PORT_SOUTH);
    else if (dstY < CurY) port = REQUEST_WIDTH'(PORT_NORTH);
  end

endmodule

// File: rtl/route_compute_unit.sv
// Routing front end: it accepts a head flit, looks up its output port (from the table or by XY)
// and holds the registered request until the switch allocator takes it.
module route_compute_unit
  import noc_route_pkg::*;
#(
  parameter int N             = 9,
  parameter int INDEX         = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int REQUEST_WIDTH = 3,
  parameter int MESH_COLS     = 3,
  parameter int MODE          = ROUTE_TABLE,
  localparam int DEST_W       = $clog2(N)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PhitPerFlit*DATA_WIDTH-1:0] head_flit,
  input  logic                            head_valid,
  output logic                            head_ready,
  output logic [REQUEST_WIDTH-1:0]        request,
  output logic                            request_valid,
  input  logic                            request_ready,
  output logic                            route_error,
  input  logic                            cfg_we,
  input  logic [DEST_W-1:0]               cfg_addr,
  input  logic [REQUEST_WIDTH-1:0]        cfg_data,
  output logic [COUNT_W-1:0]              lookup_count,
  output logic                            fsm_state
);

  // Handshakes: a transfer happens on any rising edge where valid && ready are both high.
  // Valid never waits for ready. Once valid is raised, its payload holds until the transfer.
  localparam logic [0:0] StateEmpty = 1'b0;
  localparam logic [0:0] StateFull  = 1'b1;
  localparam logic [DEST_W:0] NodeCount = (DEST_W+1)'(N);

  logic [0:0]               stateQ;
  logic [REQUEST_WIDTH-1:0] requestQ;
  logic                     errorQ;
  logic [COUNT_W-1:0]       lookupCnt;
  logic [DEST_W-1:0]        dest;
  logic                     destInRange;
  logic                     accept;
  logic                     consume;
  logic [REQUEST_WIDTH-1:0] routePort;
  logic [REQUEST_WIDTH-1:0] lookupPort;
  logic                     unusedHead;

  assign dest        = head_flit[DEST_W-1:0];
  assign unusedHead  = ^head_flit[PhitPerFlit*DATA_WIDTH-1:DEST_W];
  assign destInRange = {1'b0, dest} < NodeCount;
  assign head_ready  = (stateQ == StateEmpty) || request_ready;
  assign accept      = head_valid && head_ready;
  assign consume     = (stateQ == StateFull) && request_ready;
  assign lookupPort  = destInRange ? routePort : REQUEST_WIDTH'(PORT_LOCAL);

  generate
    if (MODE == ROUTE_TABLE) begin : gen_table
      logic [REQUEST_WIDTH-1:0] routeTable [N];

      // Reading the registered table combinationally returns the old entry on a same-cycle write.
      assign routePort = routeTable[dest];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < N; i++) routeTable[i] <= REQUEST_WIDTH'(PORT_LOCAL);
        end else if (cfg_we && ({1'b0, cfg_addr} < NodeCount)) begin
          routeTable[cfg_addr] <= cfg_data;
        end
      end
    end else begin : gen_xy
      logic unusedCfg;
      assign unusedCfg = ^{cfg_we, cfg_addr, cfg_data};

      xy_route_logic #(
        .INDEX        (INDEX),
        .MESH_COLS    (MESH_COLS),
        .DEST_W       (DEST_W),
        .REQUEST_WIDTH(REQUEST_WIDTH)
      ) u_xy (
        .dest(dest),
        .port(routePort)
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= StateEmpty;
      requestQ <= '0;
      errorQ   <= 1'b0;
    end else if (accept) begin
      stateQ   <= StateFull;
      requestQ <= lookupPort;
      errorQ   <= !destInRange;
    end else if (consume) begin
      // request keeps its last value after a drain. Only the qualifiers drop.
      stateQ <= StateEmpty;
      errorQ <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookupCnt <= '0;
    end else if (accept && (lookupCnt != '1)) begin
      lookupCnt <= lookupCnt + COUNT_W'(1);
    end
  end

  assign request       = requestQ;
  assign request_valid = (stateQ == StateFull);
  assign route_error   = errorQ;
  assign lookup_count  = lookupCnt;
  assign fsm_state     = stateQ;

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit: a table-mode and an XY-mode instance share the same stimulus
// and are compared against a queue-based behavioural model of the routing rules.
module tb_route_compute_unit;

  localparam int N = 9;
  localparam int INDEX = 4;
  localparam int MESH_COLS = 3;

  logic        clk;
  logic        rst;
  logic [15:0] head_flit;
  logic        head_valid;
  logic        request_ready;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [2:0]  cfg_data;

  logic        hr0, rv0, err0, st0;
  logic [2:0]  req0;
  logic [15:0] cnt0;
  logic        hr1, rv1, err1, st1;
  logic [2:0]  req1;
  logic [15:0] cnt1;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [6:0] exp_q[$];
  int tbl[N];
  int mLast0, mLast1, mCnt;
  bit obsHr0, obsHr1, expHr;

  route_compute_unit #(.MODE(0)) dut0 (
    .clk(clk), .rst(rst), .head_flit(head_flit), .head_valid(head_valid), .head_ready(hr0),
    .request(req0), .request_valid(rv0), .request_ready(request_ready), .route_error(err0),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .lookup_count(cnt0),
    .fsm_state(st0)
  );

  route_compute_unit #(.MODE(1)) dut1 (
    .clk(clk), .rst(rst), .head_flit(head_flit), .head_valid(head_valid), .head_ready(hr1),
    .request(req1), .request_valid(rv1), .request_ready(request_ready), .route_error(err1),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .lookup_count(cnt1),
    .fsm_state(st1)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int ref_xy(int d);
    int cx, cy, dx, dy;
    if (d >= N) return 0;
    cx = INDEX % MESH_COLS; cy = INDEX / MESH_COLS;
    dx = d % MESH_COLS;     dy = d / MESH_COLS;
    if (dx > cx) return 2;
    if (dx < cx) return 4;
    if (dy > cy) return 3;
    if (dy < cy) return 1;
    return 0;
  endfunction

  function automatic bit m_valid();
    return exp_q.size() != 0;
  endfunction

  function automatic bit m_err();
    return (exp_q.size() != 0) ? exp_q[0][6] : 1'b0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < N; i++) tbl[i] = 0;
    mLast0 = 0; mLast1 = 0; mCnt = 0;
  endtask

  // Driver: present inputs for one cycle, sample head_ready mid-cycle, advance the model at the edge.
  task automatic cycle(input bit hv, input int d, input bit rr, input bit we, input int a, input int dat);
    bit acc, cons, er;
    int r0, r1;
    head_valid = hv; head_flit = {12'($urandom), 4'(d)}; request_ready = rr;
    cfg_we = we; cfg_addr = 4'(a); cfg_data = 3'(dat);
    #3;
    obsHr0 = hr0; obsHr1 = hr1;
    expHr = !m_valid() || rr;
    acc = hv && expHr;
    cons = m_valid() && rr;
    er = (d >= N);
    r0 = er ? 0 : tbl[d];
    r1 = ref_xy(d);
    @(posedge clk);
    if (cons) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back({er, 3'(r0), 3'(r1)});
      mLast0 = r0; mLast1 = r1;
      if (mCnt != 65535) mCnt++;
    end
    if (we && a < N) tbl[a] = dat;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; head_valid = 0; head_flit = '0; request_ready = 0;
    cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL reset_valid0 got=%0b exp=0", rv0); end
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%0b exp=0", rv1); end
    checks++; if (req0 !== 3'd0) begin failures++; $display("FAIL reset_request got=%0d exp=0", req0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", err0); end
    checks++; if (cnt0 !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    rst = 1'b1;
    #1;
    checks++; if (hr0 !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%0b exp=1", hr0); end
    checks++; if (hr1 !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%0b exp=1", hr1); end
    for (int d = 0; d < N; d++) begin
      cycle(1, d, 1, 0, 0, 0);
      checks++; if (rv0 !== 1'b1) begin failures++; $display("FAIL sweep_valid d=%0d got=%0b exp=1", d, rv0); end
      checks++; if (req0 !== 3'(mLast0)) begin failures++; $display("FAIL sweep_table d=%0d got=%0d exp=%0d", d, req0, mLast0); end
    end
    cycle(0, 0, 1, 0, 0, 0);
    checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL sweep_drain got=%0b exp=0", rv0); end
    checks++; if (cnt0 !== 16'(mCnt)) begin failures++; $display("FAIL sweep_count got=%0d exp=%0d", cnt0, mCnt); end
  endtask

  task automatic test_table_program();
    cycle(0, 0, 1, 1, 7, 3);
    cycle(1, 7, 1, 0, 0, 0);
    checks++; if (req0 !== 3'd3) begin failures++; $display("FAIL prog_request got=%0d exp=3", req0); end
    checks++; if (rv0 !== 1'b1) begin failures++; $display("FAIL prog_valid got=%0b exp=1", rv0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL prog_error got=%0b exp=0", err0); end
  endtask

  task automatic test_read_before_write();
    cycle(0, 0, 1, 1, 2, 1);
    cycle(1, 2, 1, 1, 2, 4);
    checks++; if (req0 !== 3'd1) begin failures++; $display("FAIL rbw_old got=%0d exp=1", req0); end
    cycle(1, 2, 1, 0, 0, 0);
    checks++; if (req0 !== 3'd4) begin failures++; $display("FAIL rbw_new got=%0d exp=4", req0); end
  endtask

  task automatic test_xy();
    int dests[6] = '{5, 3, 1, 7, 4, 2};
    int ports[6] = '{2, 4, 1, 3, 0, 2};
    int d;
    for (int i = 0; i < 6; i++) begin
      cycle(1, dests[i], 1, 0, 0, 0);
      checks++; if (req1 !== 3'(ports[i])) begin failures++; $display("FAIL xy_fixed d=%0d got=%0d exp=%0d", dests[i], req1, ports[i]); end
    end
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 15);
      cycle(1, d, 1, 0, 0, 0);
      checks++; if (req1 !== 3'(mLast1)) begin failures++; $display("FAIL xy_rand d=%0d got=%0d exp=%0d", d, req1, mLast1); end
      checks++; if (err1 !== m_err()) begin failures++; $display("FAIL xy_err d=%0d got=%0b exp=%0b", d, err1, m_err()); end
    end
  endtask

  task automatic test_backpressure();
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 6, 0, 0, 0, 0);
      checks++; if (obsHr0 !== 1'b0) begin failures++; $display("FAIL stall_ready c=%0d got=%0b exp=0", i, obsHr0); end
      checks++; if (rv0 !== 1'b1) begin failures++; $display("FAIL stall_valid c=%0d got=%0b exp=1", i, rv0); end
      checks++; if (req0 !== 3'(mLast0) || req1 !== 3'd2) begin failures++; $display("FAIL stall_request c=%0d got=%0d/%0d exp=%0d/2", i, req0, req1, mLast0); end
      checks++; if (cnt0 !== 16'(mCnt)) begin failures++; $display("FAIL stall_count c=%0d got=%0d exp=%0d", i, cnt0, mCnt); end
    end
    checks++; if (st0 !== 1'b1) begin failures++; $display("FAIL stall_state got=%0b exp=1", st0); end
    for (int i = 0; i < 6; i++) begin
      cycle(1, $urandom_range(0, 8), 1, 0, 0, 0);
      checks++; if (obsHr0 !== 1'b1 || obsHr1 !== 1'b1) begin failures++; $display("FAIL b2b_ready c=%0d got=%0b%0b exp=11", i, obsHr0, obsHr1); end
      checks++; if (req0 !== 3'(mLast0) || req1 !== 3'(mLast1)) begin failures++; $display("FAIL b2b_request c=%0d got=%0d/%0d exp=%0d/%0d", i, req0, req1, mLast0, mLast1); end
      checks++; if (cnt0 !== 16'(mCnt)) begin failures++; $display("FAIL b2b_count c=%0d got=%0d exp=%0d", i, cnt0, mCnt); end
    end
    cycle(0, 0, 1, 0, 0, 0);
    checks++; if (rv0 !== 1'b0 || req0 !== 3'(mLast0)) begin failures++; $display("FAIL drain_hold got=%0b/%0d exp=0/%0d", rv0, req0, mLast0); end
  endtask

  task automatic test_random();
    bit hv, rr, we;
    int d, a, dat;
    for (int i = 0; i < 40; i++) begin
      hv = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 15); a = $urandom_range(0, 15); dat = $urandom_range(0, 7);
      cycle(hv, d, rr, we, a, dat);
      checks++; if (obsHr0 !== expHr) begin failures++; $display("FAIL rand_ready i=%0d got=%0b exp=%0b", i, obsHr0, expHr); end
      checks++; if (rv0 !== m_valid() || rv1 !== m_valid()) begin failures++; $display("FAIL rand_valid i=%0d got=%0b%0b exp=%0b", i, rv0, rv1, m_valid()); end
      checks++; if (req0 !== 3'(mLast0)) begin failures++; $display("FAIL rand_table i=%0d got=%0d exp=%0d", i, req0, mLast0); end
      checks++; if (req1 !== 3'(mLast1)) begin failures++; $display("FAIL rand_xy i=%0d got=%0d exp=%0d", i, req1, mLast1); end
      checks++; if (err0 !== m_err() || err1 !== m_err()) begin failures++; $display("FAIL rand_error i=%0d got=%0b%0b exp=%0b", i, err0, err1, m_err()); end
      checks++; if (cnt0 !== 16'(mCnt)) begin failures++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, cnt0, mCnt); end
    end
  endtask

  task automatic test_error();
    cycle(1, 12, 1, 0, 0, 0);
    checks++; if (req0 !== 3'd0 || req1 !== 3'd0) begin failures++; $display("FAIL oob_request got=%0d/%0d exp=0/0", req0, req1); end
    checks++; if (err0 !== 1'b1 || err1 !== 1'b1) begin failures++; $display("FAIL oob_error got=%0b%0b exp=11", err0, err1); end
    cycle(0, 0, 1, 0, 0, 0);
    checks++; if (err0 !== 1'b0 || rv0 !== 1'b0) begin failures++; $display("FAIL oob_drop got=%0b/%0b exp=0/0", err0, rv0); end
  endtask

  task automatic test_saturation();
    force dut0.lookupCnt = 16'hFFFE;
    force dut1.lookupCnt = 16'hFFFE;
    cycle(0, 0, 1, 0, 0, 0);
    release dut0.lookupCnt;
    release dut1.lookupCnt;
    mCnt = 65534;
    for (int i = 0; i < 3; i++) begin
      cycle(1, $urandom_range(0, 8), 1, 0, 0, 0);
      checks++; if (cnt0 !== 16'(mCnt) || cnt1 !== 16'(mCnt)) begin failures++; $display("FAIL sat_count i=%0d got=%0h/%0h exp=%0h", i, cnt0, cnt1, mCnt); end
    end
  endtask

  task automatic test_reset_mid_stall();
    cycle(0, 0, 1, 1, 7, 5);
    cycle(1, 5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checks++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin failures++; $display("FAIL async_valid got=%0b%0b exp=00", rv0, rv1); end
    checks++; if (cnt0 !== 16'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", cnt0); end
    model_reset();
    head_valid = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (hr0 !== 1'b1) begin failures++; $display("FAIL rerst_ready got=%0b exp=1", hr0); end
    cycle(1, 7, 1, 0, 0, 0);
    checks++; if (req0 !== 3'd0 || rv0 !== 1'b1) begin failures++; $display("FAIL rerst_table got=%0d/%0b exp=0/1", req0, rv0); end
  endtask

  initial begin
    test_reset();
    test_table_program();
    test_read_before_write();
    test_xy();
    test_backpressure();
    test_random();
    test_error();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
